// File: rtl/cipher_pkg.sv
// Type codes and FSM encoding shared between the stream-in packer and the cipher core.
package cipher_pkg;

  localparam logic [1:0] TYPE_IN_ENC = 2'b00;
  localparam logic [1:0] TYPE_IN_DEC = 2'b01;
  localparam logic [1:0] TYPE_IN_KEY = 2'b10;
  localparam logic [1:0] TYPE_IN_IV  = 2'b11;

  localparam logic [1:0] TYPE_OUT_ENC = 2'b00;
  localparam logic [1:0] TYPE_OUT_DEC = 2'b01;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Data blocks must wait for a keyed core; key and IV loads go straight through.
  function automatic logic needs_core_ready(input logic [1:0] blk_type);
    return (blk_type == TYPE_IN_ENC) || (blk_type == TYPE_IN_DEC);
  endfunction

endpackage

// File: rtl/cipher_in_packer.sv
// Packs four typed 32-bit bus words into one 128-bit block and issues it to the
// cipher core as a single-cycle vin/tin/din strobe, with strobe spacing and type-mix checks.
module cipher_in_packer
  import cipher_pkg::*;
#(
  parameter int MIN_GAP = 1,
  parameter int GAP_W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic [1:0]   s_type,
  input  logic         flush,
  input  logic         crypto_ready,
  output logic         vin,
  output logic [1:0]   tin,
  output logic [127:0] din,
  output logic         err,
  output logic         busy
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  state_t             state_reg;
  logic [1:0]         count_reg;
  logic [1:0]         blk_type_reg;
  logic [GAP_W-1:0]   gap_reg;
  logic               vin_reg;
  logic [1:0]         tin_reg;
  logic [127:0]       din_reg;

  logic [127:0]       din_buf;
  logic [127:0]       emit_data;
  logic [1:0]         slot_idx;
  logic               accept;
  logic               mix;
  logic               gap_ok;
  logic               type_ok;
  logic               last_word;
  logic               emit_now;
  logic               emit_hold;
  logic               emit;

  assign s_ready   = ~rst & ~flush & (state_reg == COLLECT);
  assign accept    = s_valid & s_ready;
  assign mix       = accept & (count_reg != 2'd0) & (s_type != blk_type_reg);
  assign slot_idx  = mix ? 2'd0 : count_reg;
  assign gap_ok    = (gap_reg == '0);
  assign type_ok   = crypto_ready | ~needs_core_ready(blk_type_reg);
  assign last_word = accept & ~mix & (count_reg == 2'd3);

  // A completing block may bypass HOLD when it is already eligible, giving
  // vin on the cycle right after the fourth word.
  assign emit_now  = last_word & gap_ok & type_ok;
  assign emit_hold = (state_reg == HOLD) & gap_ok & type_ok;
  assign emit      = emit_now | emit_hold;
  assign emit_data = emit_now ? {din_buf[127:32], s_data} : din_buf;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      logic [31:0] word_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
        end else if (accept && (slot_idx == 2'(gi))) begin
          word_reg <= s_data;
        end
      end

      assign din_buf[127-32*gi -: 32] = word_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= COLLECT;
      count_reg    <= 2'd0;
      blk_type_reg <= TYPE_IN_ENC;
      gap_reg      <= '0;
      vin_reg      <= 1'b0;
      tin_reg      <= 2'b00;
      din_reg      <= '0;
    end else begin
      vin_reg <= emit;
      tin_reg <= emit ? blk_type_reg : 2'b00;
      din_reg <= emit ? emit_data : '0;

      if (emit) begin
        gap_reg <= GAP_LOAD;
      end else if (!gap_ok) begin
        gap_reg <= gap_reg - 1'b1;
      end

      case (state_reg)
        COLLECT: begin
          if (flush) begin
            count_reg <= 2'd0;
          end else if (accept) begin
            if (mix) begin
              count_reg    <= 2'd1;
              blk_type_reg <= s_type;
            end else begin
              if (count_reg == 2'd0) begin
                blk_type_reg <= s_type;
              end
              count_reg <= count_reg + 2'd1;
              if (last_word && !emit_now) begin
                state_reg <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (emit_hold) begin
            state_reg <= COLLECT;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

  assign vin  = vin_reg;
  assign tin  = tin_reg;
  assign din  = din_reg;
  assign err  = mix;
  assign busy = (count_reg != 2'd0) | (state_reg == HOLD);

endmodule

// File: tb/tb_cipher_in_packer.sv
// Bench for cipher_in_packer: directed scenarios plus random traffic against a
// word-queue reference model, and a MIN_GAP=8 instance for strobe spacing.
module tb_cipher_in_packer;

  localparam int MAIN_GAP = 1;
  localparam int WIDE_GAP = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic [1:0]   s_type;
  logic         flush;
  logic         crypto_ready;
  logic         vin;
  logic [1:0]   tin;
  logic [127:0] din;
  logic         err;
  logic         busy;

  logic         g_valid;
  logic         g_s_ready;
  logic [31:0]  g_data;
  logic         g_vin;
  logic [1:0]   g_tin;
  logic [127:0] g_din;
  logic         g_err;
  logic         g_busy;

  always #5 clk = ~clk;

  cipher_in_packer #(.MIN_GAP(MAIN_GAP), .GAP_W(4)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_type(s_type), .flush(flush), .crypto_ready(crypto_ready), .vin(vin),
    .tin(tin), .din(din), .err(err), .busy(busy)
  );

  cipher_in_packer #(.MIN_GAP(WIDE_GAP), .GAP_W(4)) dut_gap (
    .clk(clk), .rst(rst), .s_valid(g_valid), .s_ready(g_s_ready), .s_data(g_data),
    .s_type(2'b00), .flush(1'b0), .crypto_ready(1'b1), .vin(g_vin),
    .tin(g_tin), .din(g_din), .err(g_err), .busy(g_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: accepted words of the current block, its type, whether a
  // complete block is waiting, and the cycle of the last strobe.
  logic [31:0]  m_words[$];
  logic [1:0]   m_type = 2'b00;
  bit           m_held = 1'b0;
  int           m_last_vin = -1000;
  logic         m_vin = 1'b0;
  logic [1:0]   m_tin = 2'b00;
  logic [127:0] m_din = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: check at the falling edge, advance the model, return 1ns after the rising edge.
  task automatic cycle();
    bit exp_ready;
    bit acc;
    bit exp_err;
    bit emit;
    bit elig;
    @(negedge clk);
    check("vin", 128'(vin), 128'(m_vin));
    check("tin", 128'(tin), 128'(m_tin));
    check("din", din, m_din);
    if (rst) begin
      check("s_ready_in_rst", 128'(s_ready), 128'd0);
      check("err_in_rst", 128'(err), 128'd0);
      m_words.delete();
      m_held     = 1'b0;
      m_last_vin = -1000;
      m_vin      = 1'b0;
      m_tin      = 2'b00;
      m_din      = '0;
    end else begin
      exp_ready = !flush && !m_held;
      acc       = s_valid && exp_ready;
      exp_err   = acc && (m_words.size() != 0) && (s_type != m_type);
      check("s_ready", 128'(s_ready), 128'(exp_ready));
      check("err", 128'(err), 128'(exp_err));
      check("busy", 128'(busy), 128'((m_words.size() != 0) || m_held));
      emit = 1'b0;
      if (m_held) begin
        emit = 1'b1;
      end else if (flush) begin
        m_words.delete();
      end else if (acc) begin
        if (exp_err) m_words.delete();
        if (m_words.size() == 0) m_type = s_type;
        m_words.push_back(s_data);
        if (m_words.size() == 4) emit = 1'b1;
      end
      elig = ((cyc + 1 - m_last_vin) >= MAIN_GAP) && (crypto_ready || m_type[1]);
      if (emit && !elig) begin
        emit   = 1'b0;
        m_held = 1'b1;
      end
      m_vin = emit;
      m_tin = emit ? m_type : 2'b00;
      m_din = emit ? {m_words[0], m_words[1], m_words[2], m_words[3]} : '0;
      if (emit) begin
        m_last_vin = cyc + 1;
        m_words.delete();
        m_held = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [1:0] t, input logic [31:0] d);
    s_valid = 1'b1;
    s_type  = t;
    s_data  = d;
    cycle();
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [31:0]  gw[32];
  int           gvc[$];
  logic [127:0] gdin[$];
  logic [1:0]   gtin[$];
  int           wi;
  int           acc3;
  bit           gacc;
  logic [1:0]   cur_type;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_type = 2'b00; flush = 1'b0;
    crypto_ready = 1'b0; g_valid = 1'b0; g_data = '0;
    @(posedge clk);
    #1;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Basic assembly
    crypto_ready = 1'b1;
    send(2'b00, 32'h00112233);
    send(2'b00, 32'h44556677);
    send(2'b00, 32'h8899AABB);
    send(2'b00, 32'hCCDDEEFF);
    check("basic_vin", 128'(vin), 128'd1);
    check("basic_din", din, 128'h00112233445566778899AABBCCDDEEFF);
    idle(2);

    // Ready gating: DEC block held with backpressure, then released
    crypto_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b01, 32'hA0000000 + i);
    s_valid = 1'b1; s_type = 2'b01; s_data = 32'h0BADF00D;
    idle(10);
    s_valid = 1'b0;
    idle(1);
    crypto_ready = 1'b1;
    idle(2);
    crypto_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b11, 32'hB0000000 + i);
    idle(2);

    // Type mix
    crypto_ready = 1'b1;
    send(2'b00, 32'h11111111);
    send(2'b00, 32'h22222222);
    send(2'b01, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) send(2'b01, 32'hC0000000 + i);
    check("mix_din_msw", 128'(din[127:96]), 128'(32'hDEADBEEF));
    idle(2);

    // Flush with a word presented in the same cycle
    send(2'b10, 32'h55555555);
    send(2'b10, 32'h66666666);
    flush = 1'b1;
    send(2'b10, 32'h77777777);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b10, 32'hD0000000 + i);
    idle(2);

    // Reset mid-operation
    send(2'b11, 32'hEEEE0000);
    send(2'b11, 32'hEEEE0001);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b11, 32'hF0000000 + i);
    idle(2);

    // Random traffic
    cur_type = 2'b00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 29) == 0) cur_type = 2'($urandom_range(0, 3));
      rst          = ($urandom_range(0, 149) == 0);
      flush        = ($urandom_range(0, 24) == 0);
      crypto_ready = ($urandom_range(0, 3) != 0);
      s_valid      = ($urandom_range(0, 3) != 0);
      s_type       = ($urandom_range(0, 14) == 0) ? 2'($urandom_range(0, 3)) : cur_type;
      s_data       = $urandom;
      cycle();
    end
    rst = 1'b0; flush = 1'b0; s_valid = 1'b0; crypto_ready = 1'b1;
    idle(3);

    // Strobe spacing on the MIN_GAP=8 instance, input offered every cycle
    for (int i = 0; i < 32; i++) gw[i] = $urandom;
    wi = 0;
    acc3 = -1;
    for (int n = 0; n < 400 && gvc.size() < 8; n++) begin
      g_valid = (wi < 32);
      if (wi < 32) g_data = gw[wi];
      #2;
      gacc = g_valid && g_s_ready;
      if (gacc && wi == 3) acc3 = cyc;
      cycle();
      if (gacc) wi++;
      if (g_vin === 1'b1) begin
        gvc.push_back(cyc);
        gdin.push_back(g_din);
        gtin.push_back(g_tin);
      end
    end
    g_valid = 1'b0;
    idle(2);
    check("gap_pulse_count", 128'(gvc.size()), 128'd8);
    if (gvc.size() > 0) check("gap_first_latency", 128'(gvc[0]), 128'(acc3 + 1));
    for (int i = 0; i < gvc.size() && i < 8; i++) begin
      check("gap_din", gdin[i], {gw[4*i], gw[4*i+1], gw[4*i+2], gw[4*i+3]});
      check("gap_tin", 128'(gtin[i]), 128'd0);
      if (i > 0) check("gap_spacing", 128'(gvc[i] - gvc[i-1]), 128'(WIDE_GAP));
    end
    check("gap_err", 128'(g_err), 128'd0);
    check("gap_busy_idle", 128'(g_busy), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cipher_in_packer.md
Name: cipher_in_packer

Overview:
- Transmitter side of the cipher stream-in interface. It produces the vin/tin/din single-cycle block strobes that the cipher core consumes.
- Accepts 32-bit typed words from the bus side with valid/ready handshake and assembles four of them into one 128-bit block.
- Emits the block as a one-cycle vin pulse. ENC/DEC blocks are held until the core reports crypto_ready; KEY/IV blocks are not.
- Enforces a minimum spacing between strobes and flags type-mixing errors.

Parameters:
- MIN_GAP, 1, minimum number of cycles from one vin pulse to the next. 1 means back-to-back is allowed. Legal range 1..15.
- GAP_W, 4, width of the gap counter. Must satisfy 2^GAP_W > MIN_GAP.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input word valid
- s_ready  out  1  packer can accept a word this cycle
- s_data  in  32  input word
- s_type  in  2  word type: 00 ENC, 01 DEC, 10 KEY, 11 IV
- flush  in  1  discard any partial block
- crypto_ready  in  1  cipher core keyed and ready
- vin  out  1  block strobe to core
- tin  out  2  block type to core
- din  out  128  block data to core
- err  out  1  one-cycle pulse on a type-mix error
- busy  out  1  partial or held block present

Behaviour:
- Reset: vin=0, tin=0, din=0, err=0, s_ready=0 during rst. The block enters COLLECT with word count 0, an empty block register, and the gap counter satisfied. Reset mid-block discards all held data with no output pulse.
- FSM states:
  - COLLECT: s_ready=1. A word transfers when s_valid & s_ready.
    - Word k (k=0..3) lands in din_buf[127-32k -: 32]; the first word is the MSBs.
    - Word 0 latches blk_type = s_type.
    - On word 3 accepted: go to HOLD.
  - HOLD: s_ready=0. Emit when both conditions hold:
    - gap_ok, and
    - crypto_ready, or blk_type is KEY/IV.
    - Emit cycle: vin=1, tin=blk_type, din=din_buf. Count returns to 0 and the FSM goes to COLLECT.
- Latency: the 4th word accepted in cycle N gives vin=1 in cycle N+1 at the earliest.
- vin is high for exactly one cycle per block. tin/din are valid only while vin=1 and are driven to 0 otherwise.
- Gap counter:
  - Loads MIN_GAP-1 on each vin pulse and decrements to 0.
  - gap_ok = (count==0).
  - With MIN_GAP=1, gap_ok is always true.
- Type mix: if a word is accepted with count≠0 and s_type≠blk_type:
  - err=1 for one cycle.
  - The partial block is discarded.
  - The offending word is taken as word 0 of a new block (count becomes 1, blk_type = new type).
- flush:
  - In COLLECT: count becomes 0 and the partial block is dropped.
  - A word presented in the same cycle is not accepted; s_ready is forced to 0 while flush=1.
  - In HOLD: flush is ignored, and the held block still issues.
- crypto_ready low with an ENC/DEC block in HOLD: the block waits indefinitely with s_ready=0 (backpressure). Any later rise of crypto_ready emits it the next eligible cycle.
- busy = (count≠0) or state==HOLD.
- No arithmetic beyond the 2-bit word counter (wraps 3→0 on block completion) and the GAP_W-bit down-counter (saturates at 0).

Decomposition:
- Shared package cipher_pkg holds:
  - TYPE_IN_ENC/DEC/KEY/IV (2-bit) and TYPE_OUT_ENC/DEC, shared with the core.
  - The FSM state encoding (COLLECT=0, HOLD=1).
- No sub-module needed. The gap counter stays inline.

Test Plan:
- Basic assembly: after reset, crypto_ready=1, four ENC words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles → vin one cycle after the 4th word, tin=00, din=0x00112233445566778899AABBCCDDEEFF, err=0.
- Ready gating: crypto_ready=0, four DEC words → no vin and s_ready=0 held. Raise crypto_ready at cycle 20 → vin=1 at cycle 21, tin=01. Then four IV words with crypto_ready=0 → vin issues immediately, tin=11.
- Type mix: ENC, ENC, then DEC word 0xDEADBEEF → err pulse that cycle. Three more DEC words → vin with tin=01, din[127:96]=0xDEADBEEF.
- Flush: two KEY words, flush=1 with s_valid=1 → that word is not accepted and busy drops to 0. Four new KEY words → a single vin, din formed from the new words only.
- Gap: MIN_GAP=8, eight back-to-back ENC blocks, input never stalling → successive vin pulses exactly 8 cycles apart.
- Reset mid-operation: rst asserted after 2 words → no vin. Post-reset, four IV words → vin with the fresh data; all outputs read 0 during rst.
